mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Arbitrates the single shared main-memory port between the instruction fetch unit (read-only) and the load/store unit (read/write).
- Sequences each transaction as request, grant, memory strobe, response, with round-robin fairness and halt gating of fetches.
- Aborts any transaction that the memory fails to complete within a bounded number of cycles.
- Sits between IFU/LSU and MAIN_MEMORY, replacing the direct PC-to-memory connection.

Parameters:
- ADDR_WIDTH, 32, address bus width.
- DATA_WIDTH, 32, data bus width.
- TIMEOUT_CYCLES, 16, maximum cycles in BUSY waiting for mem_valid_in before abort (>=2).

Ports:
- clock_in  in  1  core clock.
- reset_in  in  1  asynchronous active-low reset.
- halt_in  in  1  while high, no new IFU grant is issued; LSU is unaffected.
- ifu_req_in  in  1  IFU read request (level).
- ifu_addr_in  in  ADDR_WIDTH  IFU read address.
- ifu_grant_out  out  1  high while the IFU owns the port.
- ifu_valid_out  out  1  one-cycle response strobe to the IFU.
- ifu_error_out  out  1  qualifies ifu_valid_out: transaction timed out.
- ifu_data_out  out  DATA_WIDTH  registered read data.
- lsu_req_in  in  1  LSU request (level).
- lsu_we_in  in  1  1 = write, 0 = read.
- lsu_addr_in  in  ADDR_WIDTH  LSU address.
- lsu_wdata_in  in  DATA_WIDTH  LSU write data.
- lsu_be_in  in  DATA_WIDTH/8  byte enables.
- lsu_grant_out  out  1  high while the LSU owns the port.
- lsu_valid_out  out  1  one-cycle response strobe to the LSU.
- lsu_error_out  out  1  qualifies lsu_valid_out: timeout.
- lsu_rdata_out  out  DATA_WIDTH  registered read data (0 for writes).
- mem_addr_out  out  ADDR_WIDTH  latched transaction address.
- mem_wdata_out  out  DATA_WIDTH  latched write data.
- mem_be_out  out  DATA_WIDTH/8  latched byte enables (all ones for IFU).
- mem_read_out  out  1  read strobe, held through BUSY.
- mem_write_out  out  1  write strobe, held through BUSY.
- mem_rdata_in  in  DATA_WIDTH  memory read data.
- mem_valid_in  in  1  memory completion.

Behaviour:
- Reset (reset_in=0, asynchronous):
  - State becomes IDLE.
  - All outputs are 0.
  - The timeout counter is 0.
  - last_grant = LSU, so the IFU wins the first tie.
  - An in-flight transaction is dropped without any response.
- FSM states: IDLE, BUSY_IFU, BUSY_LSU, RESP.
- IDLE:
  - A candidate is eligible when its req is high; the IFU is eligible only if halt_in=0.
  - With one candidate, it wins.
  - With both, the requester other than last_grant wins.
  - On the edge: latch addr/wdata/be/we, set last_grant, go to BUSY_x, clear the counter.
  - With no candidate, stay in IDLE.
- BUSY_x:
  - The matching grant_out is 1.
  - mem_read_out = !we; mem_write_out = we. IFU transactions are always reads.
  - The counter increments each cycle.
  - If mem_valid_in=1: capture mem_rdata_in (writes capture 0), clear error, go to RESP.
  - Else, if the counter equals TIMEOUT_CYCLES-1: data = 0, error = 1, go to RESP.
  - If mem_valid_in and the final timeout cycle coincide, valid wins and there is no error.
- RESP (exactly one cycle):
  - Grant and strobes are 0.
  - The owner's valid_out = 1, with data/error registered.
  - Next state is IDLE.
- Latency:
  - Request sampled in IDLE at cycle t; strobes and grant appear at t+1.
  - With mem_valid_in at t+1, valid_out is at t+2.
  - Minimum 3 cycles per transaction; no back-to-back overlap.
- Requester rule:
  - req is level-sensitive and is resampled in the IDLE cycle after RESP.
  - A requester deasserts req in the cycle after its valid_out, unless it issues a new request with a new address.
- Changes to addr/wdata/req during BUSY are ignored (values are latched).
- mem_valid_in outside BUSY, including a late response after a timeout, is ignored.
- halt_in asserted during BUSY_IFU does not abort; it blocks only the next IFU grant.

Decomposition:
- Package core101_mem_pkg holds:
  - the FSM state encoding (2 bits);
  - requester ID constants (REQ_IFU=0, REQ_LSU=1);
  - the default TIMEOUT_CYCLES;
  - the counter width derived via $clog2(TIMEOUT_CYCLES).
- One natural sub-module: mem_arb_rr_pick, the combinational 2-way round-robin picker.
  - Inputs: the two reqs, halt, last_grant.
  - Outputs: winner and a valid flag.
- The FSM, counter and latches stay in mem_arbiter.

Test Plan:
- IFU only, addr 0x00000010, memory returns 0xDEADBEEF one cycle after the strobe:
  - mem_read_out=1 and ifu_grant_out=1 at t+1;
  - ifu_valid_out=1 with ifu_data_out=0xDEADBEEF at t+2;
  - ifu_error_out=0.
- IFU and LSU requests in the same IDLE cycle, straight after reset:
  - the IFU is served first, then the LSU;
  - with both held high, grants alternate IFU, LSU, IFU, LSU over 4 transactions.
- LSU write, addr 0x100, wdata 0x12345678, be 4'b0011:
  - mem_write_out=1 and mem_be_out=0011 during BUSY;
  - lsu_valid_out pulses with lsu_rdata_out=0.
- LSU read with mem_valid_in never asserted, TIMEOUT_CYCLES=16:
  - strobe is high for exactly 16 cycles;
  - lsu_valid_out=1 with lsu_error_out=1 and data 0;
  - a late mem_valid_in afterwards is ignored.
- halt_in=1 with both requesting:
  - only the LSU is granted;
  - the IFU is granted on the first IDLE cycle after halt_in falls.
- reset_in pulled low during BUSY_LSU:
  - all strobes, grants and valids drop to 0 immediately;
  - after release, the IFU wins the first tie.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the main-memory arbiter: FSM encoding,
// requester IDs and timeout counter sizing.
package core101_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BUSY_IFU = 2'd1,
    ST_BUSY_LSU = 2'd2,
    ST_RESP     = 2'd3
  } arb_state_e;

  typedef logic req_id_t;
  localparam req_id_t REQ_IFU = 1'b0;
  localparam req_id_t REQ_LSU = 1'b1;

  localparam int DEFAULT_TIMEOUT_CYCLES = 16;

  // Counter only has to reach TIMEOUT_CYCLES-1, so $clog2 bits suffice.
  function automatic int cnt_width(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

  localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_TIMEOUT_CYCLES);

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of IFU, LSU and main-memory signals around the arbiter.
// slave = arbiter side, master = requesters plus memory.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    halt_in;
  logic                    ifu_req_in;
  logic [ADDR_WIDTH-1:0]   ifu_addr_in;
  logic                    ifu_grant_out;
  logic                    ifu_valid_out;
  logic                    ifu_error_out;
  logic [DATA_WIDTH-1:0]   ifu_data_out;
  logic                    lsu_req_in;
  logic                    lsu_we_in;
  logic [ADDR_WIDTH-1:0]   lsu_addr_in;
  logic [DATA_WIDTH-1:0]   lsu_wdata_in;
  logic [DATA_WIDTH/8-1:0] lsu_be_in;
  logic                    lsu_grant_out;
  logic                    lsu_valid_out;
  logic                    lsu_error_out;
  logic [DATA_WIDTH-1:0]   lsu_rdata_out;
  logic [ADDR_WIDTH-1:0]   mem_addr_out;
  logic [DATA_WIDTH-1:0]   mem_wdata_out;
  logic [DATA_WIDTH/8-1:0] mem_be_out;
  logic                    mem_read_out;
  logic                    mem_write_out;
  logic [DATA_WIDTH-1:0]   mem_rdata_in;
  logic                    mem_valid_in;

  modport slave (
    input  halt_in, ifu_req_in, ifu_addr_in,
    input  lsu_req_in, lsu_we_in, lsu_addr_in, lsu_wdata_in, lsu_be_in,
    input  mem_rdata_in, mem_valid_in,
    output ifu_grant_out, ifu_valid_out, ifu_error_out, ifu_data_out,
    output lsu_grant_out, lsu_valid_out, lsu_error_out, lsu_rdata_out,
    output mem_addr_out, mem_wdata_out, mem_be_out, mem_read_out, mem_write_out
  );

  modport master (
    output halt_in, ifu_req_in, ifu_addr_in,
    output lsu_req_in, lsu_we_in, lsu_addr_in, lsu_wdata_in, lsu_be_in,
    output mem_rdata_in, mem_valid_in,
    input  ifu_grant_out, ifu_valid_out, ifu_error_out, ifu_data_out,
    input  lsu_grant_out, lsu_valid_out, lsu_error_out, lsu_rdata_out,
    input  mem_addr_out, mem_wdata_out, mem_be_out, mem_read_out, mem_write_out
  );

endinterface

// File: rtl/mem_arb_rr_pick.sv
// Combinational two-way round-robin picker between IFU and LSU.
// A halted IFU is never eligible.
module mem_arb_rr_pick
  import core101_mem_pkg::*;
(
  input  logic    ifu_req_i,
  input  logic    lsu_req_i,
  input  logic    halt_i,
  input  req_id_t last_grant_i,
  output req_id_t winner_o,
  output logic    valid_o
);

  logic ifu_ok;

  assign ifu_ok  = ifu_req_i & ~halt_i;
  assign valid_o = ifu_ok | lsu_req_i;

  always_comb begin
    winner_o = REQ_IFU;
    if (ifu_ok && lsu_req_i) begin
      // On a tie the requester that did not go last wins.
      winner_o = (last_grant_i == REQ_LSU) ? REQ_IFU : REQ_LSU;
    end else if (!ifu_ok && lsu_req_i) begin
      winner_o = REQ_LSU;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the main-memory port between IFU (reads) and LSU (reads/writes):
// grant, strobe until mem_valid_in or timeout, then a one-cycle response.
module mem_arbiter
  import core101_mem_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input logic          clock_in,
  input logic          reset_in,
  mem_arbiter_if.slave bus
);

  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_e            state_q, state_d;
  req_id_t               last_grant_q, last_grant_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]       be_q, be_d;
  logic                  we_q, we_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] ifu_data_q, ifu_data_d;
  logic [DATA_WIDTH-1:0] lsu_data_q, lsu_data_d;
  logic [DATA_WIDTH-1:0] captured;
  req_id_t               winner;
  logic                  pick_valid;
  logic                  busy;

  mem_arb_rr_pick u_pick (
    .ifu_req_i    (bus.ifu_req_in),
    .lsu_req_i    (bus.lsu_req_in),
    .halt_i       (bus.halt_in),
    .last_grant_i (last_grant_q),
    .winner_o     (winner),
    .valid_o      (pick_valid)
  );

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q      <= ST_IDLE;
      last_grant_q <= REQ_LSU;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      ifu_data_q   <= '0;
      lsu_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      we_q         <= we_d;
      err_q        <= err_d;
      ifu_data_q   <= ifu_data_d;
      lsu_data_q   <= lsu_data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    we_d         = we_q;
    err_d        = err_q;
    ifu_data_d   = ifu_data_q;
    lsu_data_d   = lsu_data_q;
    captured     = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          last_grant_d = winner;
          cnt_d        = '0;
          err_d        = 1'b0;
          if (winner == REQ_IFU) begin
            addr_d  = bus.ifu_addr_in;
            wdata_d = '0;
            be_d    = '1;
            we_d    = 1'b0;
            state_d = ST_BUSY_IFU;
          end else begin
            addr_d  = bus.lsu_addr_in;
            wdata_d = bus.lsu_wdata_in;
            be_d    = bus.lsu_be_in;
            we_d    = bus.lsu_we_in;
            state_d = ST_BUSY_LSU;
          end
        end
      end
      ST_BUSY_IFU, ST_BUSY_LSU: begin
        cnt_d = cnt_q + 1'b1;
        // Completion beats timeout when both land in the same cycle.
        if (bus.mem_valid_in) begin
          captured = we_q ? '0 : bus.mem_rdata_in;
          err_d    = 1'b0;
          state_d  = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
        if (state_d == ST_RESP) begin
          if (last_grant_q == REQ_IFU) ifu_data_d = captured;
          else                         lsu_data_d = captured;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy              = (state_q == ST_BUSY_IFU) || (state_q == ST_BUSY_LSU);
  assign bus.ifu_grant_out = (state_q == ST_BUSY_IFU);
  assign bus.lsu_grant_out = (state_q == ST_BUSY_LSU);
  assign bus.mem_read_out  = busy & ~we_q;
  assign bus.mem_write_out = busy & we_q;
  assign bus.mem_addr_out  = addr_q;
  assign bus.mem_wdata_out = wdata_q;
  assign bus.mem_be_out    = be_q;
  assign bus.ifu_valid_out = (state_q == ST_RESP) && (last_grant_q == REQ_IFU);
  assign bus.lsu_valid_out = (state_q == ST_RESP) && (last_grant_q == REQ_LSU);
  assign bus.ifu_error_out = bus.ifu_valid_out & err_q;
  assign bus.lsu_error_out = bus.lsu_valid_out & err_q;
  assign bus.ifu_data_out  = ifu_data_q;
  assign bus.lsu_rdata_out = lsu_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a transaction-level
// model: who wins, how long the strobe lasts, and what each response carries.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int T  = 16;
  localparam bit IFU = 1'b0;
  localparam bit LSU = 1'b1;

  logic clock_in = 1'b0;
  logic reset_in = 1'b0;
  always #5 clock_in = ~clock_in;

  mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)) dut (
    .clock_in (clock_in),
    .reset_in (reset_in),
    .bus      (bus)
  );

  int total = 0;
  int bad   = 0;
  bit exp_last;

  task automatic chk(input string tag, input string what,
                     input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s/%s observed=%0h expected=%0h", tag, what, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock_in);
    @(negedge clock_in);
  endtask

  // -1 = nobody eligible, otherwise the requester that should own the port.
  function automatic int predict(input bit ireq, input bit lreq, input bit halt, input bit last);
    bit ifu_ok;
    ifu_ok = ireq && !halt;
    if (ifu_ok && lreq) return last ? 0 : 1;
    if (ifu_ok) return 0;
    if (lreq) return 1;
    return -1;
  endfunction

  task automatic quiet(input string tag);
    chk(tag, "grants", 64'({bus.ifu_grant_out, bus.lsu_grant_out}), 64'(0));
    chk(tag, "strobes", 64'({bus.mem_read_out, bus.mem_write_out}), 64'(0));
    chk(tag, "valids", 64'({bus.ifu_valid_out, bus.lsu_valid_out}), 64'(0));
  endtask

  // Called at a negedge in IDLE with inputs set; returns at the negedge of RESP.
  // lat = BUSY cycle index (0-based) in which memory completes; >= T never completes.
  task automatic serve(input string tag, input bit owner, input int lat, input logic [31:0] rdata);
    logic [31:0] e_addr, e_wdata, e_data;
    logic [3:0]  e_be;
    bit          e_we, e_err;
    int          e_strobes, cyc, strobes;
    e_addr    = owner ? bus.lsu_addr_in : bus.ifu_addr_in;
    e_we      = owner ? bus.lsu_we_in : 1'b0;
    e_be      = owner ? bus.lsu_be_in : 4'hF;
    e_wdata   = bus.lsu_wdata_in;
    e_err     = (lat < 0) || (lat >= T);
    e_strobes = e_err ? T : lat + 1;
    e_data    = (e_err || e_we) ? 32'h0 : rdata;
    step();
    chk(tag, "ifu_grant", 64'(bus.ifu_grant_out), 64'(owner == IFU));
    chk(tag, "lsu_grant", 64'(bus.lsu_grant_out), 64'(owner == LSU));
    chk(tag, "mem_read", 64'(bus.mem_read_out), 64'(!e_we));
    chk(tag, "mem_write", 64'(bus.mem_write_out), 64'(e_we));
    chk(tag, "mem_addr", 64'(bus.mem_addr_out), 64'(e_addr));
    chk(tag, "mem_be", 64'(bus.mem_be_out), 64'(e_be));
    if (owner == LSU && e_we) chk(tag, "mem_wdata", 64'(bus.mem_wdata_out), 64'(e_wdata));
    exp_last = owner;
    cyc = 0;
    strobes = 0;
    while ((bus.ifu_grant_out || bus.lsu_grant_out) && cyc < T + 4) begin
      if (bus.mem_read_out || bus.mem_write_out) strobes++;
      bus.mem_valid_in = (cyc == lat);
      bus.mem_rdata_in = (cyc == lat) ? rdata : $urandom;
      bus.ifu_addr_in  = $urandom;
      bus.lsu_addr_in  = $urandom;
      bus.lsu_wdata_in = $urandom;
      step();
      cyc++;
    end
    bus.mem_valid_in = 1'b0;
    chk(tag, "strobe_cycles", 64'(strobes), 64'(e_strobes));
    chk(tag, "ifu_valid", 64'(bus.ifu_valid_out), 64'(owner == IFU));
    chk(tag, "lsu_valid", 64'(bus.lsu_valid_out), 64'(owner == LSU));
    chk(tag, "resp_grants", 64'({bus.ifu_grant_out, bus.lsu_grant_out}), 64'(0));
    chk(tag, "addr_held", 64'(bus.mem_addr_out), 64'(e_addr));
    if (owner == IFU) begin
      chk(tag, "ifu_error", 64'(bus.ifu_error_out), 64'(e_err));
      chk(tag, "ifu_data", 64'(bus.ifu_data_out), 64'(e_data));
    end else begin
      chk(tag, "lsu_error", 64'(bus.lsu_error_out), 64'(e_err));
      chk(tag, "lsu_rdata", 64'(bus.lsu_rdata_out), 64'(e_data));
    end
  endtask

  task automatic set_lsu(input bit req, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
    bus.lsu_req_in   = req;
    bus.lsu_we_in    = we;
    bus.lsu_addr_in  = addr;
    bus.lsu_wdata_in = wdata;
    bus.lsu_be_in    = be;
  endtask

  initial begin
    int w;
    int lat;
    bus.halt_in      = 1'b0;
    bus.ifu_req_in   = 1'b0;
    bus.ifu_addr_in  = '0;
    bus.mem_rdata_in = '0;
    bus.mem_valid_in = 1'b0;
    set_lsu(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Reset state
    repeat (2) @(negedge clock_in);
    quiet("reset");
    chk("reset", "mem_addr", 64'(bus.mem_addr_out), 64'(0));
    chk("reset", "mem_be", 64'(bus.mem_be_out), 64'(0));
    reset_in = 1'b1;
    exp_last = LSU;
    step();

    // Tie straight after reset, then strict alternation with both held
    bus.ifu_req_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.ifu_addr_in = 32'h1000 + 32'(i * 4);
      set_lsu(1'b1, 1'b0, 32'h2000 + 32'(i * 4), 32'h0, 4'hF);
      serve($sformatf("tie%0d", i), (i % 2 == 0) ? IFU : LSU, i, $urandom);
      step();
    end

    // IFU alone, memory completes in the first BUSY cycle
    bus.lsu_req_in  = 1'b0;
    bus.ifu_addr_in = 32'h0000_0010;
    serve("ifu_basic", IFU, 0, 32'hDEAD_BEEF);
    bus.ifu_req_in = 1'b0;
    step();

    // LSU partial write: rdata must read back as zero
    set_lsu(1'b1, 1'b1, 32'h100, 32'h1234_5678, 4'b0011);
    serve("lsu_write", LSU, 1, 32'hFFFF_FFFF);
    bus.lsu_req_in = 1'b0;
    step();

    // LSU read never completed, then a stray late mem_valid_in
    set_lsu(1'b1, 1'b0, 32'h200, 32'h0, 4'hF);
    serve("lsu_timeout", LSU, -1, 32'h0);
    bus.lsu_req_in   = 1'b0;
    bus.mem_valid_in = 1'b1;
    bus.mem_rdata_in = 32'hBAD0_BAD0;
    step();
    step();
    quiet("late_valid");
    bus.mem_valid_in = 1'b0;

    // Completion on the final timeout cycle wins over the abort
    set_lsu(1'b1, 1'b0, 32'h300, 32'h0, 4'hF);
    serve("lsu_edge", LSU, T - 1, 32'hCAFE_F00D);
    bus.lsu_req_in = 1'b0;
    step();

    // Halt blocks only the IFU
    bus.halt_in     = 1'b1;
    bus.ifu_req_in  = 1'b1;
    bus.ifu_addr_in = 32'h400;
    set_lsu(1'b1, 1'b0, 32'h500, 32'h0, 4'hF);
    serve("halt_lsu", LSU, 2, $urandom);
    bus.lsu_req_in = 1'b0;
    step();
    step();
    quiet("halt_idle");
    bus.halt_in     = 1'b0;
    bus.ifu_addr_in = 32'h404;
    serve("halt_release", IFU, 0, $urandom);
    bus.ifu_req_in = 1'b0;
    step();

    // Randomized traffic checked against the transaction-level model
    for (int i = 0; i < 40; i++) begin
      bus.ifu_req_in  = 1'($urandom_range(0, 1));
      bus.halt_in     = ($urandom_range(0, 3) == 0);
      bus.ifu_addr_in = $urandom;
      set_lsu(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
              4'($urandom_range(0, 15)));
      lat = ($urandom_range(0, 4) == 0) ? $urandom_range(T - 1, T + 3) : $urandom_range(0, 5);
      w = predict(bus.ifu_req_in, bus.lsu_req_in, bus.halt_in, exp_last);
      if (w < 0) begin
        step();
        chk($sformatf("rnd%0d", i), "idle_grants",
            64'({bus.ifu_grant_out, bus.lsu_grant_out}), 64'(0));
      end else begin
        serve($sformatf("rnd%0d", i), w[0], lat, $urandom);
        step();
      end
    end

    // Asynchronous reset in the middle of an LSU transaction
    bus.halt_in    = 1'b0;
    bus.ifu_req_in = 1'b0;
    set_lsu(1'b1, 1'b0, 32'h600, 32'h0, 4'hF);
    step();
    step();
    chk("rst_busy", "lsu_grant_before", 64'(bus.lsu_grant_out), 64'(1));
    reset_in = 1'b0;
    #1;
    quiet("rst_busy");
    chk("rst_busy", "mem_addr", 64'(bus.mem_addr_out), 64'(0));
    @(negedge clock_in);
    reset_in = 1'b1;
    exp_last = LSU;
    bus.ifu_req_in  = 1'b1;
    bus.ifu_addr_in = 32'h700;
    serve("post_rst_tie", IFU, 0, $urandom);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
